// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer
//   Multi-cycle W = N*WORDS bit add/subtract. A single N-bit ripple slice is
//   reused once per cycle, LSB word first, with the carry held in a register.
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     start, sub, cin, a, b           request and operands (sampled on accept)
//     ready, busy, done               handshake status (registered)
//     sum, carry_flag,
//     overflow_flag, zero_flag        registered result, held until next done
module wide_add_sequencer #(
  parameter int unsigned N     = 32,
  parameter int unsigned WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               sub,
  input  logic               cin,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [N*WORDS-1:0] sum,
  output logic               carry_flag,
  output logic               overflow_flag,
  output logic               zero_flag
);

  localparam int unsigned W     = N * WORDS;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     work_q, work_d;
  logic             c_q, c_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [N-1:0]     sl_a, sl_b, sl_s;
  logic             sl_co;
  logic             cy;

  // Select the operand word addressed by idx
  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int unsigned w = 0; w < WORDS; w++) begin
      if (idx_q == IDX_W'(w)) begin
        sl_a = a_q[w*N +: N];
        sl_b = b_q[w*N +: N];
      end
    end
  end

  // The one shared N-bit ripple slice: a chain of full-adder cells
  always_comb begin
    sl_s = '0;
    cy   = c_q;
    for (int unsigned i = 0; i < N; i++) begin
      sl_s[i] = sl_a[i] ^ sl_b[i] ^ cy;
      cy      = (sl_a[i] & sl_b[i]) | (cy & (sl_a[i] ^ sl_b[i]));
    end
    sl_co = cy;
  end

  // Next-state, datapath and flag logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    work_d  = work_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtract is a + ~b + 1, so the inversion and the +1 are folded
          // into the latched operand and initial carry.
          state_d = RUN;
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub | cin;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int unsigned w = 0; w < WORDS; w++) begin
          if (idx_q == IDX_W'(w)) work_d[w*N +: N] = sl_s;
        end
        c_d = sl_co;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          idx_d   = '0;
          sum_d   = work_d;
          carry_d = sl_co;
          ovf_d   = (a_q[W-1] == b_q[W-1]) & (work_d[W-1] != a_q[W-1]);
          zero_d  = (work_d == '0);
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE) || (state_d == DONE);
    busy_d  = (state_d == RUN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      work_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      work_q  <= work_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign ready         = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign sum           = sum_q;
  assign carry_flag    = carry_q;
  assign overflow_flag = ovf_q;
  assign zero_flag     = zero_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer
//   Randomized self-checking bench for wide_add_sequencer (N=8, WORDS=4).
//   Expected results come from plain 64-bit arithmetic on the full operands.
module tb_wide_add_sequencer;

  localparam int unsigned N     = 8;
  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_flag;
  logic         overflow_flag;
  logic         zero_flag;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  exp_t exp_q[$];
  int   rem = 0;

  wide_add_sequencer #(.N(N), .WORDS(WORDS)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .sub           (sub),
    .cin           (cin),
    .a             (a),
    .b             (b),
    .ready         (ready),
    .busy          (busy),
    .done          (done),
    .sum           (sum),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag),
    .zero_flag     (zero_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Reference: whole-word arithmetic, signed range test for overflow
  function automatic exp_t ref_op(input logic [31:0] ia, input logic [31:0] ib,
                                  input logic isub, input logic icin);
    exp_t          r;
    longint unsigned u;
    longint        sa, sb, sv;
    sa = $signed(ia);
    sb = $signed(ib);
    if (isub) begin
      u  = 64'h1_0000_0000 + 64'(ia) - 64'(ib);
      sv = sa - sb;
    end else begin
      u  = 64'(ia) + 64'(ib) + 64'(icin);
      sv = sa + sb + longint'(icin);
    end
    r.s = u[31:0];
    r.c = u[32];
    r.z = (u[31:0] == 32'h0);
    r.v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    return r;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_carry"}, carry_flag, 0);
    chk({tag, "_ovf"}, overflow_flag, 0);
    chk({tag, "_zero"}, zero_flag, 0);
  endtask

  task automatic chk_result(input string tag, input exp_t e);
    chk({tag, "_sum"}, sum, e.s);
    chk({tag, "_carry"}, carry_flag, e.c);
    chk({tag, "_ovf"}, overflow_flag, e.v);
    chk({tag, "_zero"}, zero_flag, e.z);
  endtask

  // One isolated operation from IDLE; checks latency, result and pulse width
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        input logic isub, input logic icin, input string tag);
    exp_t e;
    int   cyc;
    e = ref_op(ia, ib, isub, icin);
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; sub = isub; cin = icin;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; sub = ~isub; cin = ~icin;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_notready"}, ready, 0);
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'd5);
    chk_result(tag, e);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, done, 0);
    chk({tag, "_idle"}, ready, 1);
    chk({tag, "_hold"}, sum, e.s);
  endtask

  // Per-edge model of the handshake: an accept costs WORDS busy edges
  task automatic stress_edge(input logic st, input logic [31:0] sa, input logic [31:0] sb,
                             input logic ssub, input logic scin);
    logic exp_done;
    exp_t e;
    exp_done = 1'b0;
    if (rem == 0) begin
      if (st) begin
        exp_q.push_back(ref_op(sa, sb, ssub, scin));
        rem = WORDS;
      end
    end else begin
      rem--;
      if (rem == 0) exp_done = 1'b1;
    end
    #1;
    chk("stress_done", done, exp_done);
    chk("stress_ready", ready, (rem == 0));
    if (exp_done) begin
      if (exp_q.size() == 0) begin
        chk("stress_queue_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk_result("stress", e);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rs, rc;
    int          guard;

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    #12;
    chk_reset_outputs("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("idle");

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, "add_xword");
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "add_wrap");
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "add_ovf");
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, "sub_borrow");
    run_op(32'h0000_0007, 32'h0000_0007, 1'b1, 1'b1, "sub_equal");
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, "sub_ovf");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, "add_cin_wrap");

    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rb = $urandom;
      rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      if (i % 4 == 3) rb = ra;
      run_op(ra, rb, rs, rc, "rand");
    end

    // start held high with fresh operands every cycle
    rem = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ra = $urandom; rb = $urandom;
      rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      start = 1'b1; a = ra; b = rb; sub = rs; cin = rc;
      @(posedge clk);
      stress_edge(1'b1, ra, rb, rs, rc);
    end
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (rem > 0 && guard < 10) begin
      @(posedge clk);
      stress_edge(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      guard++;
    end
    chk("stress_drained", 64'(exp_q.size()), 0);

    // Reset in the middle of an operation
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, "pre_rst");
    @(negedge clk);
    start = 1'b1; a = 32'h1111_1111; b = 32'h2222_2222; sub = 1'b0; cin = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_hold_done", done, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      chk("post_rst_nodone", done, 0);
    end
    chk_reset_outputs("post_rst");
    run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
